// File: rtl/choreo_pkg.sv
// Shared definitions for the choreography sequencer and its step table.
package choreo_pkg;

  // Playback controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Bit positions of the fields inside one table entry {dur, speed, pat[2:0]}.
  localparam int PAT_LSB = 0;
  localparam int SPD_BIT = 3;
  localparam int DUR_LSB = 4;

  // Pattern select value that blanks all LEDs on the generator.
  localparam logic [2:0] PAT_ALL_OFF = 3'b111;

  // Pattern codes understood by the LED pattern generator.
  localparam logic [2:0] PAT_CODE0 = 3'd0;
  localparam logic [2:0] PAT_CODE1 = 3'd1;
  localparam logic [2:0] PAT_CODE2 = 3'd2;
  localparam logic [2:0] PAT_CODE3 = 3'd3;
  localparam logic [2:0] PAT_CODE4 = 3'd4;
  localparam logic [2:0] PAT_CODE5 = 3'd5;
  localparam logic [2:0] PAT_CODE6 = 3'd6;
  localparam logic [2:0] PAT_CODE7 = 3'd7;

endpackage

// File: rtl/choreo_step_table.sv
// Playlist storage: register file with one write port and two combinational
// read ports, cleared to all-zero (every entry an end-of-list marker) by reset.
module choreo_step_table
  import choreo_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DUR_W     = 4,
  localparam int AW       = $clog2(NUM_STEPS),
  localparam int EW       = DUR_W + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [EW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [EW-1:0] rd_data_b
);

  logic [EW-1:0] mem_q [NUM_STEPS];
  logic [EW-1:0] mem_d [NUM_STEPS];

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

  // Next contents: unchanged except for the addressed entry on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage registers; reset empties the playlist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/choreo_sequencer.sv
// Playlist controller: steps through the stored table on beat ticks and drives
// the LED pattern generator's pattern, speed, pause and enable inputs.
module choreo_sequencer
  import choreo_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DUR_W     = 4,
  localparam int AW       = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DUR_W+3:0] wr_data,
  output logic [2:0]       pat_sel,
  output logic             speed_sel,
  output logic             pause,
  output logic             ena,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  localparam int EW = DUR_W + 4;

  state_e           state_q, state_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic [DUR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]       pat_sel_q, pat_sel_d;
  logic             speed_sel_q, speed_sel_d;
  logic             pause_q, pause_d;
  logic             ena_q, ena_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;

  logic             tbl_we;
  logic [AW-1:0]    rd_addr_a;
  logic [EW-1:0]    head_entry;
  logic [AW-1:0]    nxt_idx;
  logic [EW-1:0]    nxt_entry;
  logic [DUR_W-1:0] head_dur, nxt_dur;
  logic             at_end;
  logic             to_idle;

  // Writes only land while idle; during playback they are rejected.
  assign tbl_we  = wr_en && (state_q == ST_IDLE);
  assign nxt_idx = step_idx_q + 1'b1;

  // Port A supplies entry 0 for a start or a loop wrap, port B the following step.
  assign rd_addr_a = ((state_q == ST_RUN) && !at_end) ? step_idx_q : '0;
  assign head_dur  = head_entry[DUR_LSB +: DUR_W];
  assign nxt_dur   = nxt_entry[DUR_LSB +: DUR_W];
  assign at_end    = (step_idx_q == AW'(NUM_STEPS - 1)) || (nxt_dur == '0);

  choreo_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .DUR_W     (DUR_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (tbl_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (head_entry),
    .rd_addr_b (nxt_idx),
    .rd_data_b (nxt_entry)
  );

  // Next-state and next-output logic; stop beats hold, hold beats tick, tick beats start.
  always_comb begin
    state_d     = state_q;
    step_idx_d  = step_idx_q;
    beat_cnt_d  = beat_cnt_q;
    pat_sel_d   = pat_sel_q;
    speed_sel_d = speed_sel_q;
    pause_d     = pause_q;
    ena_d       = ena_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_err_d    = wr_en && (state_q != ST_IDLE);
    to_idle     = 1'b0;

    if (stop) begin
      to_idle = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (head_dur == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = ST_RUN;
              step_idx_d  = '0;
              beat_cnt_d  = head_dur;
              pat_sel_d   = head_entry[PAT_LSB +: 3];
              speed_sel_d = head_entry[SPD_BIT];
              pause_d     = 1'b0;
              ena_d       = 1'b1;
              busy_d      = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_d = ST_HOLD;
            pause_d = 1'b1;
          end else if (tick) begin
            if (beat_cnt_q > DUR_W'(1)) begin
              beat_cnt_d = beat_cnt_q - 1'b1;
            end else if (!at_end) begin
              step_idx_d  = nxt_idx;
              beat_cnt_d  = nxt_dur;
              pat_sel_d   = nxt_entry[PAT_LSB +: 3];
              speed_sel_d = nxt_entry[SPD_BIT];
            end else if (loop) begin
              step_idx_d  = '0;
              beat_cnt_d  = head_dur;
              pat_sel_d   = head_entry[PAT_LSB +: 3];
              speed_sel_d = head_entry[SPD_BIT];
            end else begin
              to_idle = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!hold) begin
            state_d = ST_RUN;
            pause_d = 1'b0;
          end
        end
        default: begin
          to_idle = 1'b1;
        end
      endcase
    end

    if (to_idle) begin
      state_d     = ST_IDLE;
      step_idx_d  = '0;
      beat_cnt_d  = '0;
      pat_sel_d   = PAT_ALL_OFF;
      speed_sel_d = 1'b0;
      pause_d     = 1'b0;
      ena_d       = 1'b0;
      busy_d      = 1'b0;
    end
  end

  // Registered state, counters and every generator-facing output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_idx_q  <= '0;
      beat_cnt_q  <= '0;
      pat_sel_q   <= PAT_ALL_OFF;
      speed_sel_q <= 1'b0;
      pause_q     <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      pat_sel_q   <= pat_sel_d;
      speed_sel_q <= speed_sel_d;
      pause_q     <= pause_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign pat_sel   = pat_sel_q;
  assign speed_sel = speed_sel_q;
  assign pause     = pause_q;
  assign ena       = ena_q;
  assign step_idx  = step_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_choreo_sequencer.sv
// Directed, table-driven bench for the choreography sequencer.
module tb_choreo_sequencer;

  logic       clk;
  logic       rst;
  logic       tick, start, stop, hold, loop, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] pat_sel;
  logic       speed_sel, pause, ena, busy, done, wr_err;
  logic [2:0] step_idx;

  int pass_count  = 0;
  int check_count = 0;

  typedef struct packed {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       st, sp, ho, lp, tk;
    logic [2:0] e_pat;
    logic       e_spd, e_pause, e_ena;
    logic [2:0] e_idx;
    logic       e_busy, e_done, e_err;
  } vec_t;

  vec_t vecs[$];

  choreo_sequencer #(.NUM_STEPS(8), .DUR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .loop      (loop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pat_sel   (pat_sel),
    .speed_sel (speed_sel),
    .pause     (pause),
    .ena       (ena),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                              input logic st, input logic sp, input logic ho, input logic lp,
                              input logic tk, input logic [2:0] pat, input logic spd,
                              input logic pa, input logic en, input logic [2:0] idx,
                              input logic bz, input logic dn, input logic er);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.st = st; v.sp = sp; v.ho = ho; v.lp = lp; v.tk = tk;
    v.e_pat = pat; v.e_spd = spd; v.e_pause = pa; v.e_ena = en;
    v.e_idx = idx; v.e_busy = bz; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  // Write while idle: outputs stay at idle values.
  function automatic vec_t wr(input logic [2:0] a, input logic [7:0] d);
    return mk(1'b1, a, d, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0, 3'd0, 0, 0, 0);
  endfunction

  function automatic vec_t ctl(input logic st, input logic sp, input logic ho, input logic lp,
                               input logic tk, input logic [2:0] pat, input logic spd,
                               input logic pa, input logic en, input logic [2:0] idx,
                               input logic bz, input logic dn);
    return mk(1'b0, 3'd0, 8'h00, st, sp, ho, lp, tk, pat, spd, pa, en, idx, bz, dn, 1'b0);
  endfunction

  task automatic applyStimulus(input vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    start = v.st; stop = v.sp; hold = v.ho; loop = v.lp; tick = v.tk;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {pat_sel, speed_sel, pause, ena, step_idx, busy, done, wr_err};
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got pat=%0d spd=%b pause=%b ena=%b idx=%0d busy=%b done=%b err=%b, want pat=%0d spd=%b pause=%b ena=%b idx=%0d busy=%b done=%b err=%b",
               name, got[11:9], got[8], got[7], got[6], got[5:3], got[2], got[1], got[0],
               exp[11:9], exp[8], exp[7], exp[6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(name, {v.e_pat, v.e_spd, v.e_pause, v.e_ena, v.e_idx, v.e_busy, v.e_done, v.e_err});
  endtask

  initial begin
    logic [2:0] p;
    logic [7:0] d;

    // Two-step list, no loop: pat 0 for 2 ticks, pat 2/fast for 3 ticks, then done.
    vecs.push_back(wr(3'd0, 8'h20));
    vecs.push_back(wr(3'd1, 8'h3A));
    vecs.push_back(wr(3'd2, 8'h00));
    vecs.push_back(ctl(1,0,0,0,0, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,0,0, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd7,0,0,0,3'd0,0,1));
    vecs.push_back(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    // Same list looping: seven ticks wrap back to step 0 and on into step 1.
    vecs.push_back(ctl(1,0,0,1,0, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    // Step 1 down to two beats left, then hold over four ticks.
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,1,1,0, 3'd2,1,1,1,3'd1,1,0));
    for (int i = 0; i < 4; i++) vecs.push_back(ctl(0,0,1,1,1, 3'd2,1,1,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,0, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,0,0,1,1, 3'd0,0,0,1,3'd0,1,0));
    // Rejected write during playback, then stop+tick+start together.
    vecs.push_back(mk(1'b1, 3'd1, 8'hFF, 0,0,0,1,0, 3'd0,0,0,1,3'd0,1,0,1));
    vecs.push_back(ctl(1,1,0,1,1, 3'd7,0,0,0,3'd0,0,0));
    // Replay: entry 1 still pat 2 / fast; start while busy does not restart.
    vecs.push_back(ctl(1,0,0,0,0, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(1,0,0,0,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,0,0,0,1, 3'd2,1,0,1,3'd1,1,0));
    vecs.push_back(ctl(0,1,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    // Full table of one-beat steps, no loop: runs to the last index, then done.
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      d = {4'h1, p[0], p};
      vecs.push_back(wr(p, d));
    end
    vecs.push_back(ctl(1,0,0,0,0, 3'd0,0,0,1,3'd0,1,0));
    for (int i = 1; i < 8; i++) begin
      p = 3'(i);
      vecs.push_back(ctl(0,0,0,0,1, p,p[0],0,1,p,1,0));
    end
    vecs.push_back(ctl(0,0,0,0,1, 3'd7,0,0,0,3'd0,0,1));
    vecs.push_back(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    // Empty list: start gives an immediate done and never goes busy.
    vecs.push_back(wr(3'd0, 8'h00));
    vecs.push_back(ctl(1,0,0,0,0, 3'd7,0,0,0,3'd0,0,1));
    vecs.push_back(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    // Full table looping: the last index wraps to step 0.
    vecs.push_back(wr(3'd0, 8'h10));
    vecs.push_back(ctl(1,0,0,1,0, 3'd0,0,0,1,3'd0,1,0));
    for (int i = 1; i < 8; i++) begin
      p = 3'(i);
      vecs.push_back(ctl(0,0,0,1,1, p,p[0],0,1,p,1,0));
    end
    vecs.push_back(ctl(0,0,0,1,1, 3'd0,0,0,1,3'd0,1,0));
    vecs.push_back(ctl(0,1,0,0,0, 3'd7,0,0,0,3'd0,0,0));

    rst = 1'b1;
    applyStimulus(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", {3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of step 3.
    runVec(ctl(1,0,0,0,0, 3'd0,0,0,1,3'd0,1,0), "mid_start");
    runVec(ctl(0,0,0,0,1, 3'd1,1,0,1,3'd1,1,0), "mid_t1");
    runVec(ctl(0,0,0,0,1, 3'd2,0,0,1,3'd2,1,0), "mid_t2");
    runVec(ctl(0,0,0,0,1, 3'd3,1,0,1,3'd3,1,0), "mid_t3");
    applyStimulus(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", {3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    runVec(ctl(1,0,0,0,0, 3'd7,0,0,0,3'd0,0,1), "start_after_reset");
    runVec(ctl(0,0,0,0,0, 3'd7,0,0,0,3'd0,0,0), "idle_after_reset");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/choreo_sequencer.md
# choreo_sequencer

Playlist controller for the 8-LED pattern generator. It stores a programmable list of steps, each step being a pattern, a speed and a duration in beats. It plays the list by driving the generator's `pat_sel`, `speed_sel`, `pause` and `ena` inputs. It sits between the board/host control inputs and the pattern generator, and advances on a 1-cycle beat strobe derived from the 8 Hz system clock.

## Interface
- `NUM_STEPS`, default 8: playlist depth (power of 2, 2..16).
- `DUR_W`, default 4: duration field width in beats.
- `clk` input, 1: system clock (8 Hz domain shared with the generator).
- `rst` input, 1: asynchronous, active-high reset.
- `tick` input, 1: beat strobe, one `clk` cycle wide.
- `start` input, 1: pulse; begin playback from step 0.
- `stop` input, 1: pulse; abort playback.
- `hold` input, 1: level; freeze playback while high.
- `loop` input, 1: level; sampled at end of list; 1 means wrap to step 0.
- `wr_en` input, 1: table write strobe.
- `wr_addr` input, log2(NUM_STEPS): table entry index.
- `wr_data` input, DUR_W+4: entry `{dur, speed, pat[2:0]}`.
- `pat_sel` output, 3: to generator.
- `speed_sel` output, 1: to generator.
- `pause` output, 1: to generator.
- `ena` output, 1: to generator.
- `step_idx` output, log2(NUM_STEPS): current step.
- `busy` output, 1: high in RUN or HOLD.
- `done` output, 1: 1-cycle pulse at natural end of a non-looping list.
- `wr_err` output, 1: 1-cycle pulse on a rejected write.

## Operation
- States: IDLE, RUN, HOLD.
- Table entry with `dur==0` is the end-of-list marker. Entries past it are never played.
- IDLE:
  - Outputs `pat_sel=3'b111` (all off), `speed_sel=0`, `pause=0`, `ena=0`, `busy=0`.
  - Writes are accepted.
- `start` in IDLE:
  - If entry 0 has `dur==0`: pulse `done`, stay in IDLE.
  - Otherwise: go to RUN, set `step_idx=0`, load `beat_cnt=dur[0]`, drive `pat_sel`/`speed_sel` from entry 0, set `ena=1`.
- RUN, on `tick`:
  - If `beat_cnt>1`: decrement `beat_cnt`.
  - If `beat_cnt==1`: advance to the next step.
- Advance:
  - `nxt=step_idx+1`.
  - End of list means `step_idx==NUM_STEPS-1` or `dur[nxt]==0`.
  - Not at end: load entry `nxt`.
  - At end with `loop=1`: load entry 0.
  - At end with `loop=0`: go to IDLE and pulse `done`.
- RUN with `hold=1` goes to HOLD:
  - `pause=1`; `ena`, `pat_sel` and `speed_sel` unchanged; ticks ignored; `beat_cnt` frozen.
  - `hold=0` returns to RUN with `pause=0`.
- `stop` in any state goes to IDLE next cycle with IDLE outputs. `done` does not pulse.
- `start` while `busy` is ignored.
- `wr_en` while `busy`: the write is dropped and `wr_err` pulses.
- Priority within one cycle: `stop` > `hold` > `tick` > `start`.
  - A tick coincident with `hold` entry is lost.
  - A tick coincident with `stop` is lost.
- Width rules:
  - `beat_cnt` is DUR_W bits and never underflows (reloads at 1).
  - `step_idx` wraps only via the loop rule.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE, all table entries 0, `beat_cnt=0`.
  - `pat_sel=3'b111`, `speed_sel=0`, `pause=0`, `ena=0`, `step_idx=0`.
  - `busy=0`, `done=0`, `wr_err=0`.
- `start` in cycle N: `busy`, `ena` and entry-0 `pat_sel` are valid at N+1.
- The final `tick` of a step in cycle N: the new `step_idx`/`pat_sel`/`speed_sel` are valid at N+1.
- A step with `dur=d` occupies exactly d ticks.
- `hold` rising in cycle N gives `pause=1` at N+1. `hold` falling in cycle M gives `pause=0` at M+1.
- `done` is high for exactly the one cycle in which `busy` first reads 0.
- A write at cycle N is visible to a `start` issued at N+1.
- Reset asserted mid-playback clears immediately (asynchronous). The table is lost.

## Structure
- Package `choreo_pkg` holds:
  - The state encoding.
  - The entry field offsets (`PAT_LSB=0`, `SPD_BIT=3`, `DUR_LSB=4`).
  - `PAT_ALL_OFF=3'b111`.
  - Pattern code constants 0..7 shared with the generator.
- Sub-module `choreo_step_table`:
  - NUM_STEPS×(DUR_W+4) register file.
  - One write port and two combinational read ports (current step and `nxt`).
  - Async reset to zero.
- FSM and `beat_cnt` live in the top level.

## Test plan
- Load `{2,0,3'b000}`, `{3,1,3'b010}`, then `dur=0` at index 2; `loop=0`; `start`; 5 ticks. Required: `pat_sel` 0 for 2 ticks, then 2 with `speed_sel=1` for 3 ticks, then `done` pulse and `pat_sel=3'b111`.
- Same list with `loop=1`, 7 ticks. Required: `step_idx` sequence 0,0,1,1,1,0,0; `done` never pulses.
- RUN in step 1 with `beat_cnt=2`; `hold` high for 4 ticks, then low, then 2 ticks. Required: `pause=1` during hold; `step_idx` stays 1 until the 2nd post-hold tick.
- Write during RUN. Required: `wr_err` pulses; a readback after `stop` shows the entry unchanged. `stop`+`tick`+`start` in the same cycle gives IDLE with no `done`.
- All 8 entries with `dur=1`, `loop=0`. Required: 8 ticks reach `step_idx=7`, then IDLE with `done`. Entry 0 with `dur=0` plus `start` gives an immediate `done` and `busy` stays 0.
- Assert `rst` mid-step 3. Required: all outputs at reset values in the same cycle; `start` afterwards gives an immediate `done` (table cleared).
